dqs_burst_seq: RTL
==================

Name: dqs_burst_seq

Overview:
- Sequences the differential DQS bidirectional I/O buffers for DDR3 write and read bursts.
- Accepts one burst command at a time and drives the per-lane `dqs_data` and `dqs_tri` inputs of the IOBUFDS pair through preamble, toggle, postamble and bus-turnaround phases.
- For reads, keeps the pads tristated and raises a capture window for the receive path.
- Sits between the PHY command sequencer and the DQS pad instances.

Parameters:
- `LANES`, 2, number of DQS byte lanes; all lanes are driven identically.
- `PREAMBLE_CYCLES`, 1, preamble length in clk cycles; must be >= 1.
- `POSTAMBLE_CYCLES`, 1, postamble length in clk cycles; must be >= 1.
- `LEN_W`, 4, width of the burst-length field.

Ports:
- `clk` input 1: single clock; every output is registered on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: burst command present.
- `cmd_ready` output 1: high only in IDLE; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_write` input 1: 1 = write burst (drive DQS), 0 = read burst (listen).
- `cmd_len` input `LEN_W`: number of DQS periods minus 1; one period = 2 clk cycles.
- `dqs_data` output `LANES`: value driven toward the pad buffer input.
- `dqs_tri` output `LANES`: pad tristate control; 1 = high-Z.
- `rd_window` output 1: read capture window for the receive path.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at burst end.

Behaviour:
- Reset values (asynchronous, on `rst_n` low):
  - `dqs_tri` = all 1; `dqs_data` = 0; `rd_window` = 0; `busy` = 0; `done` = 0; `cmd_ready` = 1.
  - State = IDLE; counters and latched command = 0.
- States and transitions:
  - IDLE -> PRE on accept.
  - PRE -> BURST after `PREAMBLE_CYCLES` cycles.
  - BURST -> POST after 2*(`cmd_len`+1) cycles.
  - POST -> GAP after `POSTAMBLE_CYCLES` cycles.
  - GAP -> IDLE after 1 cycle.
- Command latching: `cmd_write` and `cmd_len` are latched on accept. Input changes after acceptance are ignored.
- Latency: accept at edge N; outputs reflect PRE from edge N+1.
- Write burst outputs:
  - PRE: `dqs_tri` = 0, `dqs_data` = 0.
  - BURST: `dqs_tri` = 0, `dqs_data` = 1,0,1,0,... starting with 1 in the first BURST cycle.
  - POST: `dqs_tri` = 0, `dqs_data` = 0.
  - GAP: `dqs_tri` = 1, `dqs_data` = 0.
- Read burst outputs:
  - `dqs_tri` = 1 and `dqs_data` = 0 throughout.
  - `rd_window` = 1 exactly during the BURST cycles, 0 otherwise.
- `done` = 1 during the single GAP cycle. `cmd_ready` returns to 1 on the cycle after GAP.
- Total busy cycles per burst: `PREAMBLE_CYCLES` + 2*(`cmd_len`+1) + `POSTAMBLE_CYCLES` + 1.
- No back-to-back bursts: GAP is always inserted. A `cmd_valid` held during a burst waits, with no loss and no double accept.
- `cmd_len` = 2^`LEN_W`-1 is legal and gives the maximum burst. The phase counter is `LEN_W`+1 bits wide so it never wraps.
- Reset asserted mid-burst returns all outputs to reset values immediately (asynchronous); the pads go high-Z.
- `cmd_valid` arriving in the same cycle as reset release is not accepted until the first edge with `rst_n` high.
- All `LANES` bits of `dqs_data` and `dqs_tri` are always equal.

Decomposition:
- Shared package (ddr3 PHY package):
  - State encoding constants IDLE/PRE/BURST/POST/GAP (3-bit).
  - Default preamble and postamble constants.
- One natural sub-module, `dqs_phase_cnt`: loadable down-counter of width `LEN_W`+1.
  - Inputs: load, load value, decrement.
  - Output: terminal-count flag.
  - Reused for every phase length.

Test Plan:
- Reset then idle: `rst_n` low 3 cycles, release -> `dqs_tri` = 2'b11, `dqs_data` = 0, `cmd_ready` = 1, `busy` = 0, `done` = 0 stable for 10 cycles.
- Write, `cmd_len` = 0, defaults:
  - Accept at cycle 0 -> cycles 1..4: `dqs_tri` = 00, `dqs_data` = 00,11,00,00.
  - Cycle 5: `dqs_tri` = 11, `done` = 1.
  - Cycle 6: `cmd_ready` = 1.
- Read, `cmd_len` = 3:
  - Accept at cycle 0 -> `dqs_tri` = 11 throughout.
  - `rd_window` = 1 for cycles 2..9 (8 cycles).
  - `done` at cycle 11.
- Max write, `cmd_len` = 15: exactly 32 BURST cycles with alternating data starting 1; `busy` for 35 cycles; no counter wrap.
- `cmd_valid` held continuously with write `cmd_len` = 1:
  - Second accept occurs exactly 1 cycle after `done`.
  - Exactly 2 `done` pulses over 2 bursts.
  - `dqs_tri` = 11 during each GAP.
- Reset mid-write: assert `rst_n` low during BURST -> `dqs_tri` = 11 and `dqs_data` = 0 before the next clock edge; after release, a new read command behaves as in the read scenario.

Source files
------------

// File: rtl/dqs_burst_seq_pkg.sv
// Shared DDR3 PHY definitions for the DQS burst sequencer: phase encoding and
// default preamble/postamble lengths.
package dqs_burst_seq_pkg;

  localparam int STATE_W       = 3;
  localparam int DEF_PREAMBLE  = 1;
  localparam int DEF_POSTAMBLE = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_BURST = 3'd2,
    ST_POST  = 3'd3,
    ST_GAP   = 3'd4
  } dqs_state_e;

  // A burst of len+1 DQS periods lasts 2*(len+1) clk cycles; the counter is
  // loaded with that minus one, which is simply {len, 1'b1}.
  function automatic logic [15:0] burst_load(input logic [14:0] len);
    return {len, 1'b1};
  endfunction

endpackage

// File: rtl/dqs_phase_cnt.sv
// Loadable down-counter shared by every DQS phase; tc flags the last cycle of
// the phase currently loaded.
module dqs_phase_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (load)
      cnt_q <= load_val;
    else if (dec && (cnt_q != '0))
      cnt_q <= cnt_q - 1'b1;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/dqs_burst_seq.sv
// DQS pad sequencer: walks one write/read burst through preamble, toggle,
// postamble and a turnaround gap, driving the IOBUFDS data/tristate inputs.
module dqs_burst_seq
  import dqs_burst_seq_pkg::*;
#(
  parameter int LANES            = 2,
  parameter int PREAMBLE_CYCLES  = DEF_PREAMBLE,
  parameter int POSTAMBLE_CYCLES = DEF_POSTAMBLE,
  parameter int LEN_W            = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [LANES-1:0] dqs_data,
  output logic [LANES-1:0] dqs_tri,
  output logic             rd_window,
  output logic             busy,
  output logic             done
);

  localparam int CW = LEN_W + 1;
  localparam logic [CW-1:0] PRE_LD  = CW'(PREAMBLE_CYCLES - 1);
  localparam logic [CW-1:0] POST_LD = CW'(POSTAMBLE_CYCLES - 1);

  dqs_state_e       state_q, state_d;
  logic             wr_q;
  logic [LEN_W-1:0] len_q;
  logic             ph_load, ph_tc;
  logic [CW-1:0]    ph_val;
  logic             accept;

  logic             wr_d, drive_d, tog_d, rdw_d;
  logic [15:0]      burst_ld;

  assign accept   = cmd_valid && (state_q == ST_IDLE);
  assign burst_ld = burst_load(15'(len_q));

  dqs_phase_cnt #(.W(CW)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (!ph_load),
    .tc       (ph_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q  <= cmd_write;
        len_q <= cmd_len;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ph_load = 1'b0;
    ph_val  = '0;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        state_d = ST_PRE;
        ph_load = 1'b1;
        ph_val  = PRE_LD;
      end
      ST_PRE: if (ph_tc) begin
        state_d = ST_BURST;
        ph_load = 1'b1;
        ph_val  = burst_ld[CW-1:0];
      end
      ST_BURST: if (ph_tc) begin
        state_d = ST_POST;
        ph_load = 1'b1;
        ph_val  = POST_LD;
      end
      ST_POST: if (ph_tc) state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the pads see each phase on
  // the same edge the FSM enters it.
  always_comb begin
    wr_d    = accept ? cmd_write : wr_q;
    drive_d = wr_d && ((state_d == ST_PRE) || (state_d == ST_BURST) ||
                       (state_d == ST_POST));
    // First toggle cycle drives 1, then invert the currently driven level.
    tog_d   = wr_d && (state_d == ST_BURST) &&
              ((state_q == ST_BURST) ? ~dqs_data[0] : 1'b1);
    rdw_d   = !wr_d && (state_d == ST_BURST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dqs_tri   <= '1;
      dqs_data  <= '0;
      rd_window <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      dqs_tri   <= {LANES{~drive_d}};
      dqs_data  <= {LANES{tog_d}};
      rd_window <= rdw_d;
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_GAP);
      cmd_ready <= (state_d == ST_IDLE);
    end
  end

endmodule
